dcache_sram_nway: RTL and testbench

DCACHE_SRAM_NWAY -- requirements
Module: dcache_sram_nway

---
 rtl/dcache_sram_nway_pkg.sv | 8 +
 rtl/dcache_sram_nway_lru.sv | 33 +++
 rtl/dcache_sram_nway.sv | 148 ++++++++++++++
 tb/tb_dcache_sram_nway.sv | 122 ++++++++++++
 4 files changed

// File: rtl/dcache_sram_nway_pkg.sv
// dcache_sram_nway_pkg: default geometry and FSM states shared by the cache tag/data store.
package dcache_sram_nway_pkg;
  localparam int DEF_WAYS = 2;
  localparam int DEF_SETS = 16;
  localparam int DEF_TAG_W = 23;
  localparam int DEF_LINE_W = 256;
  typedef enum logic {S_IDLE, S_FLUSH} state_e;
endpackage

// File: rtl/dcache_sram_nway_lru.sv
// lru_age_nway: victim choice and MRU age update for one set of an N-way cache.
module lru_age_nway #(
  parameter int WAYS = 2,
  parameter int AW = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]         valid_i,
  input  logic [WAYS-1:0][AW-1:0] age_i,
  input  logic                    touch_i,
  input  logic [AW-1:0]           way_i,
  output logic [AW-1:0]           victim_o,
  output logic [WAYS-1:0][AW-1:0] age_o
);
  logic          found;
  logic [AW-1:0] ref_age;
  always_comb begin
    victim_o = '0;
    found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = AW'(w);
        found = 1'b1;
      end
    end
    if (!found)
      for (int w = 0; w < WAYS; w++)
        if (age_i[w] == AW'(WAYS - 1)) victim_o = AW'(w);
    ref_age = age_i[way_i];
    age_o = age_i;
    if (touch_i)
      for (int w = 0; w < WAYS; w++)
        age_o[w] = (AW'(w) == way_i) ? '0 : (age_i[w] < ref_age) ? age_i[w] + 1'b1 : age_i[w];
  end
endmodule

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way set-associative tag/data store with age-based LRU and a flush sweep.
module dcache_sram_nway
  import dcache_sram_nway_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  parameter int SETS = DEF_SETS,
  parameter int TAG_W = DEF_TAG_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int SET_W = $clog2(SETS)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic              dirty_i,
  input  logic [SET_W-1:0]  addr_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              ack_o,
  output logic              hit_o,
  output logic [LINE_W-1:0] data_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              vic_valid_o,
  output logic              vic_dirty_o
);
  localparam int AW = $clog2(WAYS);

  state_e                          state_q, state_d;
  logic [SET_W-1:0]                cnt_q, cnt_d;
  logic [SETS-1:0][WAYS-1:0]       valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0][WAYS-1:0][AW-1:0] age_q, age_d;
  logic [TAG_W-1:0]                tags_q [SETS][WAYS];
  logic [TAG_W-1:0]                tags_d [SETS][WAYS];
  logic [LINE_W-1:0]               lines_q [SETS][WAYS];
  logic [LINE_W-1:0]               lines_d [SETS][WAYS];
  logic                            ack_q, ack_d, hit_q, hit_d;
  logic                            vic_valid_q, vic_valid_d, vic_dirty_q, vic_dirty_d;
  logic [LINE_W-1:0]               data_q, data_d;
  logic [TAG_W-1:0]                tag_q, tag_d;

  logic                            accept, hit;
  logic [AW-1:0]                   hit_way, victim, sel_way;
  logic [WAYS-1:0][AW-1:0]         age_next;

  assign ready_o = state_q == S_IDLE;
  assign accept = req_i & ready_o;
  assign sel_way = hit ? hit_way : victim;
  assign {ack_o, hit_o, data_o, tag_o, vic_valid_o, vic_dirty_o} =
         {ack_q, hit_q, data_q, tag_q, vic_valid_q, vic_dirty_q};

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[addr_i][w] && tags_q[addr_i][w] == tag_i) begin
        hit = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  lru_age_nway #(.WAYS(WAYS)) u_lru (
    .valid_i (valid_q[addr_i]),
    .age_i   (age_q[addr_i]),
    .touch_i (hit | we_i),
    .way_i   (sel_way),
    .victim_o(victim),
    .age_o   (age_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    age_d = age_q;
    tags_d = tags_q;
    lines_d = lines_q;
    ack_d = accept;
    hit_d = hit_q;
    data_d = data_q;
    tag_d = tag_q;
    vic_valid_d = vic_valid_q;
    vic_dirty_d = vic_dirty_q;
    if (accept) begin
      hit_d = hit;
      data_d = lines_q[addr_i][sel_way];
      tag_d = tags_q[addr_i][sel_way];
      vic_valid_d = !hit && valid_q[addr_i][victim];
      vic_dirty_d = !hit && dirty_q[addr_i][victim];
      age_d[addr_i] = age_next;
      if (we_i) begin
        lines_d[addr_i][sel_way] = data_i;
        tags_d[addr_i][sel_way] = tag_i;
        valid_d[addr_i][sel_way] = 1'b1;
        dirty_d[addr_i][sel_way] = dirty_i;
      end
    end
    if (state_q == S_IDLE && flush_i) begin
      state_d = S_FLUSH;
      cnt_d = '0;
    end
    if (state_q == S_FLUSH) begin
      valid_d[cnt_q] = '0;
      dirty_d[cnt_q] = '0;
      for (int w = 0; w < WAYS; w++) age_d[cnt_q][w] = AW'(w);
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == SET_W'(SETS - 1)) ? S_IDLE : S_FLUSH;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
      ack_q <= 1'b0;
      hit_q <= 1'b0;
      data_q <= '0;
      tag_q <= '0;
      vic_valid_q <= 1'b0;
      vic_dirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      age_q <= age_d;
      ack_q <= ack_d;
      hit_q <= hit_d;
      data_q <= data_d;
      tag_q <= tag_d;
      vic_valid_q <= vic_valid_d;
      vic_dirty_q <= vic_dirty_d;
    end
  end

  // Line and tag storage survive reset and flush; only the status bits are cleared.
  always_ff @(posedge clk_i) begin
    tags_q <= tags_d;
    lines_q <= lines_d;
  end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway: directed checks of lookup, fill, LRU eviction, flush and reset.
module tb_dcache_sram_nway;
  logic         clk = 1'b0, rst_n = 1'b1;
  logic         req = 1'b0, we = 1'b0, dirty = 1'b0, flush = 1'b0;
  logic [3:0]   addr = '0;
  logic [22:0]  tag = '0;
  logic [255:0] wdata = '0;
  logic         ready, ack, hit, vic_valid, vic_dirty;
  logic [255:0] rdata;
  logic [22:0]  rtag;
  int           n_checks = 0, n_fails = 0;
  int           low_cnt, ack_cnt;
  logic [255:0] pat_aa, pat_22, pat_d0, pat_dd, pat_99;

  dcache_sram_nway dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .dirty_i(dirty),
    .addr_i(addr), .tag_i(tag), .data_i(wdata), .flush_i(flush),
    .ready_o(ready), .ack_o(ack), .hit_o(hit), .data_o(rdata), .tag_o(rtag),
    .vic_valid_o(vic_valid), .vic_dirty_o(vic_dirty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic acc(input logic w, input logic d, input logic [3:0] s, input logic [22:0] t,
                     input logic [255:0] dat);
    req = 1'b1; we = w; dirty = d; addr = s; tag = t; wdata = dat;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; dirty = 1'b0;
  endtask

  initial begin
    pat_aa = {32{8'hAA}}; pat_22 = {32{8'h22}}; pat_d0 = {32{8'hD0}};
    pat_dd = {32{8'hDD}}; pat_99 = {32{8'h99}};
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ack", ack, 0); chk("rst_hit", hit, 0); chk("rst_data", rdata, 0);
    chk("rst_tag", rtag, 0); chk("rst_ready", ready, 1);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    acc(0, 0, 4'd3, 23'h1A, 0);
    chk("first_ack", ack, 1); chk("first_hit", hit, 0);
    chk("first_vic_valid", vic_valid, 0); chk("first_ready", ready, 1);
    @(posedge clk); #1;
    chk("ack_pulse", ack, 0);

    acc(1, 0, 4'd3, 23'h1A, pat_aa);
    chk("fill_hit", hit, 0); chk("fill_vic_valid", vic_valid, 0);
    acc(0, 0, 4'd3, 23'h1A, 0);
    chk("b2b_ack", ack, 1); chk("b2b_hit", hit, 1); chk("b2b_data", rdata, pat_aa);
    chk("b2b_tag", rtag, 23'h1A);

    acc(1, 0, 4'd5, 23'h1, {32{8'h11}});
    acc(1, 0, 4'd5, 23'h2, pat_22);
    acc(0, 0, 4'd5, 23'h1, 0);
    chk("lru_read_hit", hit, 1);
    acc(1, 0, 4'd5, 23'h3, {32{8'h33}});
    chk("evict_hit", hit, 0); chk("evict_tag", rtag, 23'h2);
    chk("evict_vic_valid", vic_valid, 1); chk("evict_vic_dirty", vic_dirty, 0);
    chk("evict_data", rdata, pat_22);
    acc(0, 0, 4'd5, 23'h1, 0);
    chk("mru_kept", hit, 1);
    acc(0, 0, 4'd5, 23'h2, 0);
    chk("evicted_gone", hit, 0);

    acc(1, 0, 4'd7, 23'h10, pat_d0);
    acc(1, 1, 4'd7, 23'h10, pat_dd);
    chk("whit_hit", hit, 1); chk("whit_vic_valid", vic_valid, 0);
    acc(1, 0, 4'd7, 23'h11, {32{8'hEE}});
    acc(1, 0, 4'd7, 23'h12, {32{8'hFF}});
    chk("dirty_evict_tag", rtag, 23'h10); chk("dirty_evict_vd", vic_dirty, 1);
    chk("dirty_evict_vv", vic_valid, 1); chk("dirty_evict_data", rdata, pat_dd);

    req = 1'b1; we = 1'b0; addr = 4'd3; tag = 23'h1A; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_req_ack", ack, 1); chk("flush_req_hit", hit, 1);
    low_cnt = 0; ack_cnt = 0;
    while (!ready && low_cnt < 40) begin
      low_cnt++;
      @(posedge clk); #1;
      ack_cnt += int'(ack);
    end
    req = 1'b0; flush = 1'b0;
    chk("flush_len", low_cnt, 16); chk("flush_drop", ack_cnt, 0);
    acc(0, 0, 4'd3, 23'h1A, 0);
    chk("post_flush_s3", hit, 0); chk("post_flush_vv", vic_valid, 0);
    chk("post_flush_line", rdata, pat_aa);
    acc(0, 0, 4'd5, 23'h1, 0);
    chk("post_flush_s5", hit, 0);
    acc(0, 0, 4'd7, 23'h11, 0);
    chk("post_flush_s7", hit, 0);

    acc(1, 1, 4'd9, 23'h55, pat_99);
    req = 1'b1; addr = 4'd9; tag = 23'h55; flush = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; flush = 1'b0;
    chk("pre_rst_data", rdata, pat_99);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", rdata, 0); chk("mid_rst_hit", hit, 0);
    chk("mid_rst_tag", rtag, 0); chk("mid_rst_ready", ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("post_rst_ready", ready, 1);
    acc(0, 0, 4'd9, 23'h55, 0);
    chk("post_rst_ack", ack, 1); chk("post_rst_miss", hit, 0);
    chk("post_rst_vv", vic_valid, 0);
    acc(1, 0, 4'd9, 23'h66, pat_22);
    acc(0, 0, 4'd9, 23'h66, 0);
    chk("post_rst_hit", hit, 1); chk("post_rst_data", rdata, pat_22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
